// File: rtl/cnu_row_scheduler.sv
// Serial check-node controller: collects one row of v2c messages into the slot bank
// feeding the min-sum tree, latches its result, then streams c2v messages in slot order.
module cnu_row_scheduler #(
  parameter int W      = 5,
  parameter int DMAX   = 20,
  parameter int IDXW   = 5,
  parameter int OFFSET = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W:0]          in_msg,
  input  logic                in_last,
  output logic [W*DMAX-1:0]   tree_x,
  input  logic [W-1:0]        tree_min1,
  input  logic [W-1:0]        tree_min2,
  input  logic [IDXW-1:0]     tree_min1_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W:0]          out_msg,
  output logic                out_last,
  output logic                busy
);

  localparam int CW = $clog2(DMAX + 1);
  localparam int SW = $clog2(DMAX);
  localparam logic [W-1:0] OFF = W'(OFFSET);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] EVAL    = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  logic [1:0]      state;
  logic [W-1:0]    slot [DMAX];
  logic [DMAX-1:0] sgn;
  logic            parity;
  logic [CW-1:0]   deg_cnt;
  logic [CW-1:0]   emit_cnt;
  logic [W-1:0]    m1;
  logic [W-1:0]    m2;
  logic [IDXW-1:0] mi;

  logic            in_fire;
  logic            out_fire;
  logic            row_done;
  logic            emit_done;
  logic [SW-1:0]   wr_idx;
  logic [SW-1:0]   rd_idx;
  logic [W-1:0]    sel;
  logic [W-1:0]    mag;

  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == EMIT);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    row_done  = in_last || (deg_cnt == CW'(DMAX - 1));
    emit_done = (emit_cnt == deg_cnt - CW'(1));
    wr_idx    = deg_cnt[SW-1:0];
    rd_idx    = emit_cnt[SW-1:0];
    // mi may point at a padding slot; then no edge matches and all get m1
    sel       = (32'(emit_cnt) == 32'(mi)) ? m2 : m1;
    mag       = (sel > OFF) ? sel - OFF : '0;
    out_msg   = out_valid ? {parity ^ sgn[rd_idx], mag} : '0;
    out_last  = out_valid && emit_done;
    busy      = (state != COLLECT) || (deg_cnt != '0);
    tree_x    = '0;
    for (int unsigned k = 0; k < DMAX; k++) begin
      tree_x[W*k +: W] = slot[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      for (int unsigned k = 0; k < DMAX; k++) slot[k] <= '1;
      sgn      <= '0;
      parity   <= 1'b0;
      deg_cnt  <= '0;
      emit_cnt <= '0;
      m1       <= '0;
      m2       <= '0;
      mi       <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            slot[wr_idx] <= in_msg[W-1:0];
            sgn[wr_idx]  <= in_msg[W];
            parity       <= parity ^ in_msg[W];
            deg_cnt      <= deg_cnt + CW'(1);
            if (row_done) state <= EVAL;
          end
        end
        EVAL: begin
          m1    <= tree_min1;
          m2    <= tree_min2;
          mi    <= tree_min1_index;
          state <= EMIT;
        end
        EMIT: begin
          if (out_fire) begin
            if (emit_done) begin
              // clear the bank back to padding so the next row starts clean
              for (int unsigned k = 0; k < DMAX; k++) slot[k] <= '1;
              sgn      <= '0;
              parity   <= 1'b0;
              deg_cnt  <= '0;
              emit_cnt <= '0;
              state    <= COLLECT;
            end else begin
              emit_cnt <= emit_cnt + CW'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_row_scheduler.sv
// Bench for cnu_row_scheduler: two instances (OFFSET 0 and 1) against an extrinsic-min
// reference model, plus hand-computed expectations for the directed rows.
module tb_cnu_row_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [5:0]  in_msg = '0;

  logic        in_ready0, out_valid0, out_last0, busy0;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [5:0]  out_msg0, out_msg1;
  logic [99:0] tree_x0, tree_x1;
  logic [4:0]  t0_m1, t0_m2, t0_idx, t1_m1, t1_m2, t1_idx;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Reference min-sum tree: smallest, second smallest, lowest index of the smallest.
  function automatic logic [14:0] tree_eval(input logic [99:0] x);
    logic [4:0] a, b, ix, v;
    a = 5'd31; b = 5'd31; ix = 5'd0;
    for (int k = 0; k < 20; k++) begin
      v = x[5*k +: 5];
      if (v < a) begin b = a; a = v; ix = 5'(k); end
      else if (v < b) b = v;
    end
    return {a, b, ix};
  endfunction

  assign {t0_m1, t0_m2, t0_idx} = tree_eval(tree_x0);
  assign {t1_m1, t1_m2, t1_idx} = tree_eval(tree_x1);

  cnu_row_scheduler #(.W(5), .DMAX(20), .IDXW(5), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_msg(in_msg),
    .in_last(in_last), .tree_x(tree_x0), .tree_min1(t0_m1), .tree_min2(t0_m2),
    .tree_min1_index(t0_idx), .out_valid(out_valid0), .out_ready(out_ready),
    .out_msg(out_msg0), .out_last(out_last0), .busy(busy0));

  cnu_row_scheduler #(.W(5), .DMAX(20), .IDXW(5), .OFFSET(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_msg(in_msg),
    .in_last(in_last), .tree_x(tree_x1), .tree_min1(t1_m1), .tree_min2(t1_m2),
    .tree_min1_index(t1_idx), .out_valid(out_valid1), .out_ready(out_ready),
    .out_msg(out_msg1), .out_last(out_last1), .busy(busy1));

  task automatic chk(input string nm, input logic [99:0] act, input logic [99:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         cnt = 0;
  int         mags [20];
  bit         sgns [20];
  bit         pending = 1'b0;
  int         age = 0;
  logic [6:0] q0 [$];
  logic [6:0] q1 [$];

  // Each c2v is the minimum over every other slot (padding included) and the XOR of other signs.
  task automatic build_expect();
    int mn, v, m1v;
    bit s;
    for (int e = 0; e < cnt; e++) begin
      mn = 31;
      s  = 1'b0;
      for (int j = 0; j < 20; j++) begin
        if (j != e) begin
          v = (j < cnt) ? mags[j] : 31;
          if (v < mn) mn = v;
          if (j < cnt) s ^= sgns[j];
        end
      end
      m1v = (mn > 1) ? mn - 1 : 0;
      q0.push_back({(e == cnt - 1), s, 5'(mn)});
      q1.push_back({(e == cnt - 1), s, 5'(m1v)});
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending = 1'b0; age = 0; cnt = 0;
      q0.delete(); q1.delete();
    end else if (pending) begin
      if (age == 0) age = 1;
      else if (out_ready && q0.size() > 0 && q1.size() > 0) begin
        logic lastb;
        lastb = q0[0][6];
        void'(q0.pop_front());
        void'(q1.pop_front());
        if (lastb) begin pending = 1'b0; cnt = 0; end
      end
    end else if (in_valid) begin
      mags[cnt] = int'(in_msg[4:0]);
      sgns[cnt] = in_msg[5];
      cnt++;
      if (in_last || cnt == 20) begin
        build_expect();
        pending = 1'b1;
        age = 0;
      end
    end
  end

  // ---------------- compare process + output log ----------------
  logic [5:0]  log0 [32];
  logic [5:0]  log1 [32];
  logic        loglast0 [32];
  int          log_n = 0;
  logic        prev_val = 1'b0, prev_ordy = 1'b1;
  logic [5:0]  prev_msg0, prev_msg1;
  logic [99:0] tx;
  logic        exp_val, exp_rdy, exp_busy;

  always @(negedge clk) begin
    exp_rdy  = !pending;
    exp_val  = pending && (age >= 1);
    exp_busy = pending || (cnt != 0);
    for (int k = 0; k < 20; k++) tx[5*k +: 5] = (k < cnt) ? 5'(mags[k]) : 5'd31;
    chk("in_ready0", in_ready0, exp_rdy);
    chk("in_ready1", in_ready1, exp_rdy);
    chk("out_valid0", out_valid0, exp_val);
    chk("out_valid1", out_valid1, exp_val);
    chk("busy0", busy0, exp_busy);
    chk("busy1", busy1, exp_busy);
    chk("tree_x0", tree_x0, tx);
    chk("tree_x1", tree_x1, tx);
    if (exp_val) begin
      if (q0.size() == 0 || q1.size() == 0) chk("queue_empty", 1'b1, 1'b0);
      else begin
        chk("out_msg0", out_msg0, q0[0][5:0]);
        chk("out_last0", out_last0, q0[0][6]);
        chk("out_msg1", out_msg1, q1[0][5:0]);
        chk("out_last1", out_last1, q1[0][6]);
      end
      if (prev_val && !prev_ordy) begin
        chk("hold_msg0", out_msg0, prev_msg0);
        chk("hold_msg1", out_msg1, prev_msg1);
      end
      if (out_ready && log_n < 32) begin
        log0[log_n] = out_msg0;
        log1[log_n] = out_msg1;
        loglast0[log_n] = out_last0;
        log_n++;
      end
    end
    if (rst) begin
      chk("rst_out_msg0", out_msg0, 6'd0);
      chk("rst_out_last0", out_last0, 1'b0);
    end
    prev_val  = exp_val;
    prev_ordy = out_ready;
    prev_msg0 = out_msg0;
    prev_msg1 = out_msg1;
  end

  // ---------------- out_ready pattern 1,0,0,1 ----------------
  logic tog_en = 1'b0;
  int   ph = 0;
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      out_ready = (ph == 0) || (ph == 3);
      ph = (ph + 1) % 4;
    end else begin
      out_ready = 1'b1;
      ph = 0;
    end
  end

  // ---------------- stimulus ----------------
  int row_a [19] = '{30, 12, 15, 18, 22, 19, 5, 7, 8, 9, 29, 16, 12, 11, 7, 8, 2, 1, 5};
  int last_wait = 0;

  task automatic send_beat(input logic [5:0] msg, input logic last);
    int waited = 0;
    in_valid = 1'b1; in_msg = msg; in_last = last;
    @(negedge clk);
    while (!in_ready0 && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) chk("in_handshake_timeout", 1'b1, 1'b0);
    last_wait = waited;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((pending || cnt != 0) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk("idle_timeout", (waited < 1000), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_row_a();
    logic [5:0] e0, e1;
    int nlast = 0;
    chk("a_beats", log_n, 19);
    for (int e = 0; e < 19; e++) begin
      e0 = {(e == 0 || e == 3), (e == 17) ? 5'd2 : 5'd1};
      e1 = {(e == 0 || e == 3), (e == 17) ? 5'd1 : 5'd0};
      chk("a_edge_off0", log0[e], e0);
      chk("a_edge_off1", log1[e], e1);
      if (loglast0[e]) nlast++;
    end
    chk("a_last_edge18", loglast0[18], 1'b1);
    chk("a_last_count", nlast, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_out_msg", out_msg0, 6'd0);
    chk("rst_out_last", out_last0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_tree_x", tree_x0, {100{1'b1}});
    @(posedge clk); #1;
    rst = 1'b0;

    // Row A, out_ready held high
    log_n = 0;
    for (int i = 0; i < 19; i++) send_beat({(i == 0 || i == 3), 5'(row_a[i])}, (i == 18));
    wait_idle();
    check_row_a();

    // 20 beats with no in_last, then a 21st beat that must stall until the row drains
    log_n = 0;
    for (int i = 0; i < 20; i++) send_beat({(i == 19), 5'(i + 3)}, 1'b0);
    send_beat(6'd9, 1'b1);
    chk("stall_cycles", last_wait, 21);
    wait_idle();
    chk("r20_beats", log_n, 21);
    chk("r20_edge0", log0[0], 6'h24);
    chk("r20_edge19", log0[19], 6'h03);
    chk("r20_last19", loglast0[19], 1'b1);
    chk("r20_last18", loglast0[18], 1'b0);
    chk("r21_deg1", log0[20], 6'h1f);
    chk("r21_last", loglast0[20], 1'b1);
    chk("r21_deg1_off1", log1[20], 6'h1e);

    // deg=1
    log_n = 0;
    send_beat(6'd6, 1'b1);
    wait_idle();
    chk("deg1_beats", log_n, 1);
    chk("deg1_msg", log0[0], 6'h1f);
    chk("deg1_last", loglast0[0], 1'b1);
    chk("deg1_msg_off1", log1[0], 6'h1e);

    // abort a partial row with reset, then Row A with a stalling sink
    log_n = 0;
    for (int i = 0; i < 7; i++) send_beat({(i == 0 || i == 3), 5'(row_a[i])}, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_no_output", log_n, 0);
    tog_en = 1'b1;
    for (int i = 0; i < 19; i++) send_beat({(i == 0 || i == 3), 5'(row_a[i])}, (i == 18));
    wait_idle();
    tog_en = 1'b0;
    check_row_a();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
